tile_move_sequencer: RTL
========================

TILE_MOVE_SEQUENCER -- requirements
Module: tile_move_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set move-request FIFO depth (power of two, >=2).
REQ-002 Parameter START_LOC, default 4'b1010, SHALL set the space location after reset: {row[3:2], col[1:0]}, rows/cols 0..2.
REQ-003 clk  in  1  clock; all state SHALL update on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 req_valid  in  1  requester offers a move.
REQ-006 req_dir  in  2  requested direction of the space: 00 LEFT, 01 RIGHT, 10 UP, 11 DOWN.
REQ-007 req_ready  out  1  sequencer accepts the request this cycle.
REQ-008 dp_ready  in  1  tile datapath can take a move this cycle.
REQ-009 solved  in  1  datapath reports all nine tiles in place.
REQ-010 move_en  out  1  registered one-cycle strobe: datapath applies move_dir.
REQ-011 move_dir  out  2  registered direction accompanying move_en.
REQ-012 rej_valid  out  1  registered one-cycle pulse: a queued move was discarded.
REQ-013 space_loc  out  4  tracked space location.
REQ-014 move_count  out  10  number of moves issued, saturating.
REQ-015 done  out  1  high while in SOLVED state.

Function
REQ-016 States RUN and SOLVED; reset SHALL enter RUN.
REQ-017 Handshake SHALL complete at an edge where req_valid && req_ready; req_dir SHALL then be pushed into the FIFO.
REQ-018 req_ready SHALL be (state==RUN) && (FIFO not full); it SHALL NOT depend on a same-cycle pop.
REQ-019 Pop SHALL occur at an edge where state==RUN, FIFO non-empty and dp_ready==1; no pop otherwise.
REQ-020 Same-edge push and pop SHALL leave occupancy unchanged; no bypass of an empty FIFO.
REQ-021 Popped move is legal iff: LEFT col>0; RIGHT col<2; UP row>0; DOWN row<2; and not the opposite of the last issued direction (while a last direction exists).
REQ-022 Legal pop: in the following cycle move_en=1, move_dir=popped direction; at the pop edge space_loc SHALL update (LEFT col-1, RIGHT col+1, UP row-1, DOWN row+1), last direction SHALL update, move_count SHALL increment unless already 1023.
REQ-023 Illegal pop: in the following cycle rej_valid=1, move_en=0; space_loc, last direction and move_count SHALL be unchanged.
REQ-024 Latency: request handshaked at edge E, head of an otherwise empty FIFO, dp_ready=1 -> move_en or rej_valid high in the cycle after edge E+1.
REQ-025 move_en and rej_valid SHALL never be high in the same cycle; each SHALL be high at most one cycle per pop.
REQ-026 RUN->SOLVED SHALL occur at an edge where solved==1 and move_en==0 and no pop occurs.
REQ-027 On entering SOLVED the FIFO SHALL be flushed; in SOLVED req_ready=0, no pops, done=1, all counters frozen; exit only by reset.
REQ-028 space_loc SHALL never leave rows/cols 0..2.

Reset
REQ-029 Reset SHALL override all activity, including mid-handshake and SOLVED.
REQ-030 Reset values: state RUN, FIFO empty, req_ready=1, move_en=0, move_dir=00, rej_valid=0, space_loc=START_LOC, move_count=0, done=0, no last direction.

Verification
REQ-031 Reset, then idle cycle -> req_ready=1, move_en=0, space_loc=1010, move_count=0, done=0.
REQ-032 dp_ready=1, push UP at edge E -> move_en=1, move_dir=10 in the cycle after E+1; space_loc=0110, move_count=1.
REQ-033 From reset push RIGHT -> rej_valid pulse, no move_en, space_loc=1010, move_count=0.
REQ-034 Push UP then DOWN back-to-back -> UP issued, DOWN rejected; space_loc=0110, move_count=1.
REQ-035 dp_ready=0, push 5 requests on consecutive cycles -> first 4 accepted, req_ready=0 thereafter, 5th not accepted; raise dp_ready -> 4 pops on 4 consecutive edges.
REQ-036 solved=1 with FIFO empty -> done=1 and req_ready=0 after next edge; assert reset -> done=0, req_ready=1, space_loc=1010.

Source files
------------

// File: rtl/tile_move_sequencer_if.sv
// Move-request handshake between a requester and the tile move sequencer.
// The requester drives valid/dir and the sequencer answers with ready.
interface tile_move_sequencer_if;
    logic       req_valid;
    logic [1:0] req_dir;
    logic       req_ready;

    modport master (
        output req_valid,
        output req_dir,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_dir,
        output req_ready
    );
endinterface

// File: rtl/tile_move_sequencer.sv
// Queues requested moves of the 3x3 puzzle's empty space, checks each for legality,
// and issues legal moves to the tile datapath until it reports the puzzle solved.
module tile_move_sequencer #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [3:0]  START_LOC = 4'b1010
) (
    input  logic                        clk,
    input  logic                        reset,
    tile_move_sequencer_if.slave        req,
    input  logic                        dp_ready,
    input  logic                        solved,
    output logic                        move_en,
    output logic [1:0]                  move_dir,
    output logic                        rej_valid,
    output logic [3:0]                  space_loc,
    output logic [9:0]                  move_count,
    output logic                        done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    typedef enum logic {
        ST_RUN,
        ST_SOLVED
    } state_t;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    state_t        state;
    state_t        state_next;

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          flush;

    logic [1:0]    head;
    logic [1:0]    row;
    logic [1:0]    col;
    logic          in_bounds;
    logic          legal;
    logic [3:0]    next_loc;
    logic          has_last;
    logic [1:0]    last_dir;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign push  = req.req_valid && req.req_ready;
    assign head  = mem[rd_ptr];
    assign row   = space_loc[3:2];
    assign col   = space_loc[1:0];

    always_ff @(posedge clk) begin
        if (reset) state <= ST_RUN;
        else       state <= state_next;
    end

    // Solving is only recognised on a quiet edge so an in-flight move is never lost.
    always_comb begin
        state_next    = state;
        req.req_ready = 1'b0;
        pop           = 1'b0;
        flush         = 1'b0;
        done          = 1'b0;
        case (state)
            ST_RUN: begin
                req.req_ready = !full;
                pop           = !empty && dp_ready;
                if (solved && !move_en && !pop) begin
                    state_next = ST_SOLVED;
                    flush      = 1'b1;
                end
            end
            ST_SOLVED: begin
                done = 1'b1;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= req.req_dir;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        in_bounds = 1'b0;
        next_loc  = space_loc;
        case (dir_t'(head))
            DIR_LEFT: begin
                in_bounds = (col != 2'd0);
                next_loc  = {row, col - 2'd1};
            end
            DIR_RIGHT: begin
                in_bounds = (col < 2'd2);
                next_loc  = {row, col + 2'd1};
            end
            DIR_UP: begin
                in_bounds = (row != 2'd0);
                next_loc  = {row - 2'd1, col};
            end
            DIR_DOWN: begin
                in_bounds = (row < 2'd2);
                next_loc  = {row + 2'd1, col};
            end
            default: begin
                in_bounds = 1'b0;
                next_loc  = space_loc;
            end
        endcase
    end

    // Opposite directions differ only in bit 0, so undoing the last move is head == last ^ 1.
    assign legal = in_bounds && !(has_last && (head == (last_dir ^ 2'b01)));

    always_ff @(posedge clk) begin
        if (reset) begin
            move_en    <= 1'b0;
            move_dir   <= 2'b00;
            rej_valid  <= 1'b0;
            space_loc  <= START_LOC;
            move_count <= '0;
            has_last   <= 1'b0;
            last_dir   <= 2'b00;
        end else begin
            move_en   <= pop && legal;
            rej_valid <= pop && !legal;
            if (pop && legal) begin
                move_dir  <= head;
                space_loc <= next_loc;
                last_dir  <= head;
                has_last  <= 1'b1;
                if (move_count != '1) move_count <= move_count + 1'b1;
            end
        end
    end

endmodule
